wbi_fetch_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the W_B_I_Buffer read port (port B) between NUM_REQ fetch clients
//  (default: weight, bias, input). A granted client supplies a base address and a word count. The block

---
 rtl/wbi_fetch_arbiter_if.sv | 31 +++
 rtl/wbi_fetch_arbiter.sv | 141 ++++++++++++++
 tb/tb_wbi_fetch_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbi_fetch_arbiter_if.sv
// Bundle of fetch-client request lines, grant/done status, BRAM port-B and tagged read-data signals.
// The master modport is the client/BRAM side; it also supplies bram_dout.
interface wbi_fetch_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 6,
  parameter int DATA_WIDTH = 256
) ();
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic                          busy;
  logic                          bram_en;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_dout;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  logic [NUM_REQ-1:0]            rd_owner;

  modport slave (
    input  req, req_base, req_len, bram_dout,
    output grant, done, busy, bram_en, bram_addr, rd_data, rd_valid, rd_owner
  );

  modport master (
    output req, req_base, req_len, bram_dout,
    input  grant, done, busy, bram_en, bram_addr, rd_data, rd_valid, rd_owner
  );
endinterface

// File: rtl/wbi_fetch_arbiter.sv
// Round-robin sequencer sharing W_B_I_Buffer port B between fetch clients: one read per cycle,
// returning data tagged with its owner, and a done pulse aligned with the owner's last word.
module wbi_fetch_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 11,
  parameter int LEN_WIDTH    = 6,
  parameter int DATA_WIDTH   = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  wbi_fetch_arbiter_if.slave  bus
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                               r_state, w_state_nxt;
  logic [IDX_W-1:0]                     r_last, w_pick;
  logic [NUM_REQ-1:0]                   r_grant, w_done;
  logic [ADDR_WIDTH-1:0]                r_base, w_sel_base;
  logic [LEN_WIDTH-1:0]                 r_len, r_cnt, w_sel_len;
  logic [DCNT_W-1:0]                    r_dcnt;
  logic                                 w_start, w_bram_en;
  logic [READ_LATENCY-1:0]              r_vld;
  logic [READ_LATENCY-1:0][NUM_REQ-1:0] r_own;
  logic [DATA_WIDTH-1:0]                w_rd_data;

  // Scan from the farthest candidate toward last_grant+1 so the nearest requester wins.
  always_comb begin
    w_pick = r_last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (bus.req[IDX_W'((int'(r_last) + off) % NUM_REQ)])
        w_pick = IDX_W'((int'(r_last) + off) % NUM_REQ);
    end
  end

  always_comb begin
    w_sel_base = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_sel_base = bus.req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // NOTE: state and all other flops use non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_bram_en   = 1'b0;
    w_done      = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_start     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (r_len == '0) begin
          w_done      = r_grant;
          w_state_nxt = IDLE;
        end else begin
          w_bram_en = 1'b1;
          if (r_cnt == r_len - LEN_WIDTH'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The last read returns READ_LATENCY cycles after its enable, i.e. in the final DRAIN cycle.
        if (r_dcnt == DCNT_W'(READ_LATENCY - 1)) begin
          w_done      = r_grant;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_start) begin
        r_last  <= w_pick;
        r_grant <= NUM_REQ'(1) << w_pick;
        r_base  <= w_sel_base;
        r_len   <= w_sel_len;
        r_cnt   <= '0;
        r_dcnt  <= '0;
      end else if (r_state != IDLE && w_state_nxt == IDLE) begin
        r_grant <= '0;
      end
      if (w_bram_en)         r_cnt  <= r_cnt + 1'b1;
      if (r_state == DRAIN)  r_dcnt <= r_dcnt + 1'b1;
    end
  end

  // Valid/owner pipeline mirrors the BRAM read latency; reset clears in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_bram_en;
      r_own[0] <= w_bram_en ? r_grant : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign w_rd_data     = bus.bram_dout;
  assign bus.rd_data   = w_rd_data;
  assign bus.rd_valid  = r_vld[READ_LATENCY-1];
  assign bus.rd_owner  = r_own[READ_LATENCY-1];
  assign bus.grant     = r_grant;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != IDLE);
  assign bus.bram_en   = w_bram_en;
  assign bus.bram_addr = w_bram_en ? r_base + ADDR_WIDTH'(r_cnt) : '0;

endmodule

// File: tb/tb_wbi_fetch_arbiter.sv
// Self-checking bench for wbi_fetch_arbiter: a latency-matched BRAM model plus a scoreboard of
// expected (owner, address) pairs for both the read-request and returned-data sides.
module tb_wbi_fetch_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 11;
  localparam int LW  = 6;
  localparam int DW  = 256;
  localparam int LAT = 2;

  typedef struct packed {
    logic [NR-1:0] owner;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q_addr[$];
  exp_t q_data[$];

  wbi_fetch_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

  wbi_fetch_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .READ_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{5'h00, a, 5'h1F, ~a}};
  endfunction

  // BRAM model: data for the address presented in a cycle appears LAT cycles later.
  logic [DW-1:0] dq [LAT];
  always @(posedge clk) begin
    dq[0] <= pat(bus.bram_addr);
    for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
  end
  assign bus.bram_dout = dq[LAT-1];

  task automatic push_fetch(input int idx, input int base, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.owner = NR'(1) << idx;
      e.addr  = AW'((base + i) % (1 << AW));
      q_addr.push_back(e);
      q_data.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.bram_en) begin
        checks++;
        if (q_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read addr=%0d grant=%b", bus.bram_addr, bus.grant);
        end else begin
          e = q_addr.pop_front();
          if (bus.bram_addr !== e.addr || bus.grant !== e.owner) begin
            errors++;
            $display("FAIL read_req got addr=%0d grant=%b exp addr=%0d grant=%b",
                     bus.bram_addr, bus.grant, e.addr, e.owner);
          end
        end
      end
      checks++;
      if (bus.rd_valid) begin
        if (q_data.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid owner=%b", bus.rd_owner);
        end else begin
          e = q_data.pop_front();
          if (bus.rd_owner !== e.owner || bus.rd_data !== pat(e.addr)) begin
            errors++;
            $display("FAIL rd_data got owner=%b data=%h exp owner=%b addr=%0d",
                     bus.rd_owner, bus.rd_data[31:0], e.owner, e.addr);
          end
        end
      end else if (bus.rd_owner !== '0) begin
        errors++;
        $display("FAIL rd_owner_idle got=%b exp=000", bus.rd_owner);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.grant, bus.done, bus.busy, bus.bram_en, bus.rd_valid, bus.rd_owner} !== '0 ||
        bus.bram_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b done=%b busy=%b en=%b addr=%0d vld=%b own=%b exp all 0",
               bus.grant, bus.done, bus.busy, bus.bram_en, bus.bram_addr, bus.rd_valid, bus.rd_owner);
    end
    checks++;
    if (bus.rd_data !== bus.bram_dout) begin
      errors++;
      $display("FAIL rd_data_passthru got=%h exp=%h", bus.rd_data[31:0], bus.bram_dout[31:0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b grant=%b exp 0/000", bus.busy, bus.grant);
    end
  endtask

  // One client fetch; optionally drops req after drop_after reads.
  task automatic run_one(input string name, input int idx, input int base, input int len,
                         input int drop_after);
    int en_n = 0, vld_n = 0, g_n = 0, t_en = -1, t_vld = -1;
    bit got = 1'b0;
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    bus.req_base[idx*AW +: AW] = AW'(base);
    bus.req_len[idx*LW +: LW]  = LW'(len);
    push_fetch(idx, base, len);
    @(negedge clk);
    bus.req[idx] = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (bus.bram_en)  begin if (t_en < 0)  t_en = c;  en_n++;  end
      if (bus.rd_valid) begin if (t_vld < 0) t_vld = c; vld_n++; end
      if (bus.grant != '0) g_n++;
      if (drop_after > 0 && en_n >= drop_after) bus.req[idx] = 1'b0;
      if (bus.done != '0) begin
        got = 1'b1;
        checks++;
        if (bus.done !== oh || bus.grant !== oh || bus.rd_valid !== (len > 0)) begin
          errors++;
          $display("FAIL %s done got done=%b grant=%b vld=%b exp done=%b grant=%b vld=%b",
                   name, bus.done, bus.grant, bus.rd_valid, oh, oh, len > 0);
        end
      end
    end
    bus.req[idx] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout got no done exp done=%b", name, oh);
    end
    checks++;
    if (en_n != len || vld_n != len) begin
      errors++;
      $display("FAIL %s counts got en=%0d vld=%0d exp %0d/%0d", name, en_n, vld_n, len, len);
    end
    checks++;
    if (g_n != ((len == 0) ? 1 : len + LAT)) begin
      errors++;
      $display("FAIL %s grant_cycles got=%0d exp=%0d", name, g_n, (len == 0) ? 1 : len + LAT);
    end
    if (len > 0) begin
      checks++;
      if (t_en != 0 || t_vld - t_en != LAT) begin
        errors++;
        $display("FAIL %s latency got first_en=%0d en_to_vld=%0d exp 0/%0d",
                 name, t_en, t_vld - t_en, LAT);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== '0 || bus.busy !== 1'b0 || bus.grant !== '0 ||
        q_addr.size() != 0 || q_data.size() != 0) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b grant=%b qa=%0d qd=%0d exp 0/0/0/0/0",
               name, bus.done, bus.busy, bus.grant, q_addr.size(), q_data.size());
    end
  endtask

  task automatic test_rotation();
    logic [NR-1:0] order [4];
    int k = 0;
    bit prev_done = 1'b0;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    for (int i = 0; i < NR; i++) begin
      bus.req_base[i*AW +: AW] = AW'(100 * (i + 1));
      bus.req_len[i*LW +: LW]  = LW'(4);
    end
    push_fetch(0, 100, 4); push_fetch(1, 200, 4); push_fetch(2, 300, 4); push_fetch(0, 100, 4);
    @(negedge clk);
    bus.req = 3'b111;
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      if (prev_done) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== '0) begin
          errors++;
          $display("FAIL rotation_gap got busy=%b grant=%b exp 0/000", bus.busy, bus.grant);
        end
      end
      prev_done = (bus.done != '0);
      if (!$onehot0(bus.grant)) begin
        checks++; errors++;
        $display("FAIL rotation_grant_onehot got=%b", bus.grant);
      end
      if (bus.done != '0) begin
        checks++;
        if (bus.done !== order[k]) begin
          errors++;
          $display("FAIL rotation_order_%0d got=%b exp=%b", k, bus.done, order[k]);
        end
        k++;
        if (k == 4) bus.req = '0;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL rotation_timeout got dones=%0d exp=4", k);
    end
    @(negedge clk);
    checks++;
    if (q_addr.size() != 0 || q_data.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rotation_drain got qa=%0d qd=%0d busy=%b exp 0/0/0",
               q_addr.size(), q_data.size(), bus.busy);
    end
  endtask

  task automatic test_single();   run_one("single",   1, 112,  32, 0); endtask
  task automatic test_wrap();     run_one("wrap",     0, 2040, 16, 0); endtask
  task automatic test_zero_len(); run_one("zero_len", 2, 50,   0,  0); endtask
  task automatic test_drop();     run_one("drop_req", 1, 900,  8,  3); endtask

  task automatic test_reset_mid();
    int en_n = 0, k = 0;
    logic [NR-1:0] order [2];
    order[0] = 3'b001; order[1] = 3'b010;
    bus.req_base[0 +: AW] = AW'(500);
    bus.req_len[0 +: LW]  = LW'(32);
    push_fetch(0, 500, 32);
    @(negedge clk);
    bus.req[0] = 1'b1;
    for (int c = 0; c < 100 && en_n < 10; c++) begin
      @(negedge clk);
      if (bus.bram_en) en_n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (en_n != 10 || {bus.grant, bus.done, bus.busy, bus.bram_en, bus.rd_valid, bus.rd_owner} !== '0 ||
        bus.bram_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid got en_seen=%0d grant=%b done=%b busy=%b en=%b vld=%b exp 10 and all 0",
               en_n, bus.grant, bus.done, bus.busy, bus.bram_en, bus.rd_valid);
    end
    q_addr.delete();
    q_data.delete();
    bus.req_base[0 +: AW]  = AW'(700);
    bus.req_len[0 +: LW]   = LW'(3);
    bus.req_base[AW +: AW] = AW'(600);
    bus.req_len[LW +: LW]  = LW'(3);
    bus.req = 3'b011;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.done !== '0 || bus.bram_en !== 1'b0 || bus.rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got done=%b en=%b vld=%b exp 000/0/0", bus.done, bus.bram_en, bus.rd_valid);
      end
    end
    push_fetch(0, 700, 3);
    push_fetch(1, 600, 3);
    rst_n = 1'b1;
    for (int c = 0; c < 100 && k < 2; c++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        checks++;
        if (bus.done !== order[k]) begin
          errors++;
          $display("FAIL reset_regrant_%0d got=%b exp=%b", k, bus.done, order[k]);
        end
        bus.req[k] = 1'b0;
        k++;
      end
    end
    bus.req = '0;
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL reset_regrant_timeout got dones=%0d exp=2", k);
    end
    @(negedge clk);
    checks++;
    if (q_addr.size() != 0 || q_data.size() != 0) begin
      errors++;
      $display("FAIL reset_regrant_drain got qa=%0d qd=%0d exp 0/0", q_addr.size(), q_data.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_base = '0;
    bus.req_len  = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_zero_len();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
